// File: rtl/wsp_scan_sequencer_if.sv
// Interface bundling the controller-side command/status signals and the WSP wrapper signals.
// The master modport is the test controller plus wrapper side; the slave modport is the sequencer.
interface wsp_scan_sequencer_if #(
    parameter int DR_W  = 12,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic             op_ir;
    logic [CNT_W-1:0] dr_len;
    logic [DR_W-1:0]  tx_data;
    logic             busy;
    logic             done;
    logic [DR_W-1:0]  rx_data;

    logic             WSO;
    logic             SelectWIR;
    logic             CaptureWR;
    logic             ShiftWR;
    logic             UpdateWR;
    logic             WSI;

    modport master (
        output start, abort, op_ir, dr_len, tx_data, WSO,
        input  busy, done, rx_data, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
    );

    modport slave (
        input  start, abort, op_ir, dr_len, tx_data, WSO,
        output busy, done, rx_data, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
    );
endinterface

// File: rtl/wsp_scan_sequencer.sv
// IEEE 1500 WSP scan sequencer: runs one WIR or WDR scan per start strobe with registered outputs.
// Optional WSO capture into rx_data is enabled by defining WSO_CAPTURE_EN.
module wsp_scan_sequencer #(
    parameter int IR_W  = 3,
    parameter int DR_W  = 12,
    parameter int CNT_W = 4
) (
    input logic                 WRCK,
    input logic                 WRSTN,
    wsp_scan_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CAPTURE,
        S_SHIFT,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] IR_LEN = CNT_W'(IR_W);
    localparam logic [CNT_W-1:0] DR_MAX = CNT_W'(DR_W);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic [CNT_W-1:0] start_len;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op_ir_q;
    logic [DR_W-1:0]  sreg_q;

    logic             select_wir_q;
    logic             capture_q;
    logic             shift_q;
    logic             update_q;
    logic             wsi_q;
    logic             busy_q;
    logic             done_q;

    always_comb begin
        start_len = bus.dr_len;
        if (bus.op_ir) begin
            start_len = IR_LEN;
        end else if (bus.dr_len > DR_MAX) begin
            start_len = DR_MAX;
        end
    end

    // Abort overrides every transition except in IDLE, where start keeps priority.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_SETUP;
                    accept     = 1'b1;
                end
            end
            S_SETUP:   next_state = S_CAPTURE;
            S_CAPTURE: next_state = (len_q == '0) ? S_UPDATE : S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE:  next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state   <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            op_ir_q <= 1'b0;
            sreg_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_ir_q <= bus.op_ir;
                len_q   <= start_len;
                sreg_q  <= bus.tx_data;
            end else if (next_state == S_SHIFT) begin
                sreg_q <= sreg_q >> 1;
            end
            if (state == S_CAPTURE) begin
                cnt_q <= len_q - 1'b1;
            end else if (state == S_SHIFT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            select_wir_q <= 1'b0;
            capture_q    <= 1'b0;
            shift_q      <= 1'b0;
            update_q     <= 1'b0;
            wsi_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            select_wir_q <= (next_state == S_IDLE) ? 1'b0 : (accept ? bus.op_ir : op_ir_q);
            capture_q    <= (next_state == S_CAPTURE);
            shift_q      <= (next_state == S_SHIFT);
            update_q     <= (next_state == S_UPDATE);
            wsi_q        <= (next_state == S_SHIFT) ? sreg_q[0] : 1'b0;
            busy_q       <= (next_state == S_SETUP) || (next_state == S_CAPTURE) ||
                            (next_state == S_SHIFT) || (next_state == S_UPDATE);
            done_q       <= (next_state == S_DONE);
        end
    end

    assign bus.SelectWIR = select_wir_q;
    assign bus.CaptureWR = capture_q;
    assign bus.ShiftWR   = shift_q;
    assign bus.UpdateWR  = update_q;
    assign bus.WSI       = wsi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef WSO_CAPTURE_EN
    logic [DR_W-1:0]  rx_q;
    logic [CNT_W-1:0] rx_idx;

    // The counter runs N-1 down to 0, so the bit index of the current shift cycle is N-1-cnt.
    assign rx_idx = len_q - 1'b1 - cnt_q;

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            rx_q <= '0;
        end else if (accept) begin
            rx_q <= '0;
        end else if (state == S_SHIFT) begin
            rx_q[rx_idx] <= bus.WSO;
        end
    end

    assign bus.rx_data = rx_q;
`else
    logic unused_wso;
    assign unused_wso  = bus.WSO;
    assign bus.rx_data = '0;
`endif

endmodule

// File: tb/tb_wsp_scan_sequencer.sv
// Directed bench for wsp_scan_sequencer; a 1-bit WBY model loops WSI back to WSO.
// Checks cycle-exact strobe timing, clamping, abort, busy-start rejection and reset.
module tb_wsp_scan_sequencer;

    logic clk;
    logic rstN;
    logic wby;
    int   checkCount;
    int   passCount;

    wsp_scan_sequencer_if #(.DR_W(12), .CNT_W(4)) bus ();

    wsp_scan_sequencer #(.IR_W(3), .DR_W(12), .CNT_W(4)) dut (
        .WRCK  (clk),
        .WRSTN (rstN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bypass register: cleared on capture, shifts WSI in during ShiftWR.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) wby <= 1'b0;
        else if (bus.CaptureWR) wby <= 1'b0;
        else if (bus.ShiftWR) wby <= bus.WSI;
    end
    assign bus.WSO = wby;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outVector();
        return {bus.SelectWIR, bus.CaptureWR, bus.ShiftWR, bus.UpdateWR, bus.WSI, bus.busy, bus.done};
    endfunction

    // Expected {SelectWIR,CaptureWR,ShiftWR,UpdateWR,WSI,busy,done} in cycle c after the start edge.
    function automatic logic [6:0] expectedVector(int c, bit op, int n, logic [11:0] data);
        logic sel, cap, sh, upd, wsi, bsy, dn;
        sel = (c >= 1 && c <= n + 4) ? op : 1'b0;
        cap = (c == 2);
        sh  = (c >= 3 && c <= n + 2);
        wsi = 1'b0;
        if (sh) wsi = data[c - 3];
        upd = (c == n + 3);
        bsy = (c >= 1 && c <= n + 3);
        dn  = (c == n + 4);
        return {sel, cap, sh, upd, wsi, bsy, dn};
    endfunction

    // Presents a command for one edge, then scrambles inputs to show they were latched.
    task automatic applyStimulus(input bit op, input logic [3:0] len, input logic [11:0] data);
        bus.op_ir   = op;
        bus.dr_len  = len;
        bus.tx_data = data;
        bus.start   = 1'b1;
        stepCycle();
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.op_ir   = ~op;
        bus.dr_len  = ~len;
        bus.tx_data = ~data;
    endtask

    task automatic runScan(input string name, input bit op, input logic [3:0] len,
                           input logic [11:0] data, input int abortAt, input int junkAt);
        int n;
        int lastCycle;
        int shiftCount;
        int strayCount;
        logic [31:0] expRx;
        n = op ? 3 : ((len > 4'd12) ? 12 : int'(len));
        lastCycle = (abortAt > 0) ? abortAt : n + 4;
        shiftCount = 0;
        applyStimulus(op, len, data);
        for (int c = 1; c <= lastCycle; c++) begin
            checkOutput($sformatf("%s c%0d", name, c), 32'(outVector()), 32'(expectedVector(c, op, n, data)));
            if (bus.ShiftWR) shiftCount++;
            if (c == junkAt) begin
                bus.start   = 1'b1;
                bus.op_ir   = ~op;
                bus.dr_len  = 4'd3;
                bus.tx_data = 12'hF3A;
            end
            if (c == abortAt) bus.abort = 1'b1;
            stepCycle();
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        checkOutput($sformatf("%s idle", name), 32'(outVector()), 32'd0);
        if (abortAt == 0) begin
            checkOutput($sformatf("%s shifts", name), 32'(shiftCount), 32'(n));
`ifdef WSO_CAPTURE_EN
            expRx = (32'(data) << 1) & ((32'd1 << n) - 32'd1);
`else
            expRx = 32'd0;
`endif
            checkOutput($sformatf("%s rx", name), 32'(bus.rx_data), expRx);
        end else begin
            strayCount = 0;
            for (int c = 0; c < 16; c++) begin
                if (bus.UpdateWR || bus.done || bus.busy) strayCount++;
                stepCycle();
            end
            checkOutput($sformatf("%s noUpdate", name), 32'(strayCount), 32'd0);
        end
    endtask

    initial begin
        int strayCount;
        checkCount  = 0;
        passCount   = 0;
        rstN        = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.op_ir   = 1'b0;
        bus.dr_len  = 4'd0;
        bus.tx_data = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs", 32'(outVector()), 32'd0);
        checkOutput("reset rx", 32'(bus.rx_data), 32'd0);
        rstN = 1'b1;
        stepCycle();
        checkOutput("idle after reset", 32'(outVector()), 32'd0);

        $display("[TB] IR scan 3'b101");
        runScan("ir101", 1'b1, 4'd7, 12'h005, 0, 0);

        $display("[TB] DR scan 12 bits, back-to-back zero-length scan");
        runScan("dr801", 1'b0, 4'd12, 12'h801, 0, 0);
        bus.abort = 1'b1;
        runScan("drzero", 1'b0, 4'd0, 12'hFFF, 0, 0);

        $display("[TB] DR length clamp");
        runScan("clamp", 1'b0, 4'd15, 12'hA5C, 0, 0);

        $display("[TB] abort in second shift cycle, then new command");
        runScan("abort", 1'b0, 4'd12, 12'h0F3, 4, 0);
        runScan("irpost", 1'b1, 4'd0, 12'h003, 0, 0);

        $display("[TB] start ignored while busy");
        runScan("busy", 1'b0, 4'd8, 12'h0C5, 0, 4);

        $display("[TB] reset mid-shift");
        applyStimulus(1'b0, 4'd12, 12'hFFF);
        repeat (3) stepCycle();
        checkOutput("rst preShift", 32'(bus.ShiftWR), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst async outputs", 32'(outVector()), 32'd0);
        checkOutput("rst async rx", 32'(bus.rx_data), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rstN = 1'b1;
        strayCount = 0;
        for (int c = 0; c < 16; c++) begin
            stepCycle();
            if (outVector() != 7'd0) strayCount++;
        end
        checkOutput("rst quiet", 32'(strayCount), 32'd0);
        runScan("postrst", 1'b1, 4'd0, 12'h006, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
